// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
package dmem_arbiter_pkg;

    // Port indices; the owner register stores one of these.
    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Byte-enable pattern that marks an access as a read.
    localparam logic [3:0] WE_READ = 4'b0000;

    // Which port issued the most recent BRAM access.
    typedef enum logic {
        OwnC = PORT_C,
        OwnD = PORT_D
    } owner_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side memory port: one instance each for the CPU and the debug/loader port.
interface dmem_arbiter_if;
    logic        req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic [31:0] rdata;
    logic        rvalid;

    // Requester drives the access, arbiter answers.
    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/dmem_arb_starve.sv
// Fixed CPU-first arbitration with a starvation counter that guarantees the debug port service.
module dmem_arb_starve #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic c_req_i,
    input  logic d_req_i,
    output logic c_gnt_o,
    output logic d_gnt_o
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_prio;

    assign d_prio = (cnt_q == Limit);

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        c_gnt_o = 1'b0;
        d_gnt_o = 1'b0;
        if (!rst) begin
            c_gnt_o = c_req_i && (!d_req_i || !d_prio);
            d_gnt_o = d_req_i && (!c_req_i || d_prio);
        end
    end

    // Count consecutive denials of D; cleared when D is served or stops asking.
    always_comb begin
        cnt_d = cnt_q;
        if (d_gnt_o || !d_req_i) begin
            cnt_d = '0;
        end else if (c_gnt_o && !d_prio) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port, 1-cycle-latency data BRAM between the CPU (C) and debug (D) ports.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     c_bus,
    dmem_arbiter_if.slave     d_bus,
    output logic              c_stall,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    logic        c_gnt, d_gnt;
    logic        c_rvalid, d_rvalid;
    owner_e      owner_q;
    logic        rd_pending_q;
    logic [31:0] c_hold_q, d_hold_q;

    dmem_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .c_req_i (c_bus.req),
        .d_req_i (d_bus.req),
        .c_gnt_o (c_gnt),
        .d_gnt_o (d_gnt)
    );

    assign c_bus.gnt = c_gnt;
    assign d_bus.gnt = d_gnt;
    assign c_stall   = c_bus.req && !c_gnt;
    assign mem_en    = c_gnt || d_gnt;

    // Only the word-address bits reach the BRAM.
    logic unused_addr;
    assign unused_addr = ^{c_bus.addr[31:ADDR_W+2], c_bus.addr[1:0],
                           d_bus.addr[31:ADDR_W+2], d_bus.addr[1:0]};

    // Steer the granted port onto the BRAM; idle bus is all zeros.
    always_comb begin
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (c_gnt) begin
            mem_we   = c_bus.we;
            mem_addr = c_bus.addr[ADDR_W+1:2];
            mem_din  = c_bus.wdata;
        end else if (d_gnt) begin
            mem_we   = d_bus.we;
            mem_addr = d_bus.addr[ADDR_W+1:2];
            mem_din  = d_bus.wdata;
        end
    end

    // Returning read goes to the port that issued it; reset kills it immediately.
    assign c_rvalid = !rst && rd_pending_q && (owner_q == OwnC);
    assign d_rvalid = !rst && rd_pending_q && (owner_q == OwnD);

    assign c_bus.rvalid = c_rvalid;
    assign d_bus.rvalid = d_rvalid;

    // BRAM output is live only in the return cycle; otherwise show the held copy.
    always_comb begin
        c_bus.rdata = rst ? 32'h0 : c_hold_q;
        d_bus.rdata = rst ? 32'h0 : d_hold_q;
        if (c_rvalid) c_bus.rdata = mem_dout;
        if (d_rvalid) d_bus.rdata = mem_dout;
    end

    // Owner/read-pending FSM plus held return data.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OwnC;
            rd_pending_q <= 1'b0;
            c_hold_q     <= '0;
            d_hold_q     <= '0;
        end else begin
            if (c_gnt) begin
                owner_q      <= OwnC;
                rd_pending_q <= (c_bus.we == WE_READ);
            end else if (d_gnt) begin
                owner_q      <= OwnD;
                rd_pending_q <= (d_bus.we == WE_READ);
            end else begin
                rd_pending_q <= 1'b0;
            end
            if (c_rvalid) c_hold_q <= mem_dout;
            if (d_rvalid) d_hold_q <= mem_dout;
        end
    end

endmodule
